// File: rtl/axil_cfg_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_cfg_master_pkg
//  Description : Shared types and constants for the AXI4-Lite config master.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_cfg_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0]  c_resp_okay     = 2'b00;
    localparam logic [1:0]  c_resp_slverr   = 2'b10;
    localparam logic [31:0] c_timeout_rdata = 32'hDEAD_DEAD;
    localparam logic [3:0]  c_wstrb_all     = 4'hF;

endpackage : axil_cfg_master_pkg
`default_nettype wire

// File: rtl/axil_cfg_master.sv
`default_nettype none
// ============================================================================
//  Module      : axil_cfg_master
//  Description : Single-outstanding AXI4-Lite master driven by one-cycle
//                register request pulses; completion reported as a one-cycle
//                ack with read data and error flag. Optional hung-slave
//                recovery enabled by defining AXIL_CFG_MASTER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_cfg_master
    import axil_cfg_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // Request side
    input  logic                  cfg_wr,
    input  logic                  cfg_rd,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic                  cfg_busy,
    output logic                  cfg_ack,
    output logic                  cfg_err,
    output logic [31:0]           cfg_rdata,
    // AXI4-Lite write address
    output logic                  awvalid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awready,
    // AXI4-Lite write data
    output logic                  wvalid,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    input  logic                  wready,
    // AXI4-Lite write response
    input  logic                  bvalid,
    input  logic [1:0]            bresp,
    output logic                  bready,
    // AXI4-Lite read address
    output logic                  arvalid,
    output logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arready,
    // AXI4-Lite read data
    input  logic                  rvalid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    output logic                  rready
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("axil_cfg_master: TIMEOUT_CYCLES must be at least 2");
    end

    state_t                r_state;
    logic                  r_busy;
    logic                  r_ack;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic                  r_awvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  r_wvalid;
    logic [31:0]           r_wdata;
    logic                  r_bready;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_rready;

    logic w_aw_done;
    logic w_w_done;
    logic w_timeout;

    // A channel counts as done once its valid has dropped or it handshakes now.
    assign w_aw_done = !r_awvalid || awready;
    assign w_w_done  = !r_wvalid  || wready;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               w_active;

    assign w_active  = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_timeout = w_active && (r_tmo_cnt == c_tmo_last);

    // Held at zero in IDLE/DONE so the first bus cycle of every transaction starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (!w_active) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_wvalid  <= 1'b0;
            r_wdata   <= '0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_timeout) begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_bready  <= 1'b0;
                r_arvalid <= 1'b0;
                r_rready  <= 1'b0;
                r_rdata   <= c_timeout_rdata;
                r_err     <= 1'b1;
                r_ack     <= 1'b1;
                r_state   <= ST_DONE;
            end else begin
                case (r_state)
                    // DONE also accepts a new request so back-to-back traffic loses no cycle.
                    ST_IDLE, ST_DONE: begin
                        if (cfg_wr && cfg_rd) begin
                            r_err   <= 1'b1;
                            r_ack   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (cfg_wr) begin
                            r_awaddr  <= cfg_addr;
                            r_wdata   <= cfg_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= ST_WR;
                        end else if (cfg_rd) begin
                            r_araddr  <= cfg_addr;
                            r_arvalid <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_WR: begin
                        if (r_awvalid && awready) begin
                            r_awvalid <= 1'b0;
                        end
                        if (r_wvalid && wready) begin
                            r_wvalid <= 1'b0;
                        end
                        if (w_aw_done && w_w_done) begin
                            r_bready <= 1'b1;
                            r_state  <= ST_WR_RESP;
                        end
                    end
                    ST_WR_RESP: begin
                        if (bvalid) begin
                            r_bready <= 1'b0;
                            r_err    <= (bresp != c_resp_okay);
                            r_ack    <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (arready) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_state   <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (rvalid) begin
                            r_rready <= 1'b0;
                            r_rdata  <= rdata;
                            r_err    <= (rresp != c_resp_okay);
                            r_ack    <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_busy  = r_busy;
    assign cfg_ack   = r_ack;
    assign cfg_err   = r_err;
    assign cfg_rdata = r_rdata;
    assign awvalid   = r_awvalid;
    assign awaddr    = r_awaddr;
    assign wvalid    = r_wvalid;
    assign wdata     = r_wdata;
    assign wstrb     = c_wstrb_all;
    assign bready    = r_bready;
    assign arvalid   = r_arvalid;
    assign araddr    = r_araddr;
    assign rready    = r_rready;

endmodule : axil_cfg_master
`default_nettype wire

// File: doc/axil_cfg_master.md
# axil_cfg_master

Single-outstanding AXI4-Lite master that turns simple one-cycle register-request pulses from the CL control logic into AXI-Lite write/read transactions. It sits directly upstream of the AXI-Lite slave register/BRAM block and drives its aw/w/b/ar/r channels. Completion is reported back as a one-cycle ack carrying read data and an error flag.

## Interface
- ADDR_WIDTH, 64, width of cfg_addr/awaddr/araddr
- TIMEOUT_CYCLES, 256, cycles in a non-IDLE state before forced completion (used only with AXIL_CFG_MASTER_TIMEOUT_EN)
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  write request pulse
- cfg_rd  in  1  read request pulse
- cfg_addr  in  ADDR_WIDTH  request byte address
- cfg_wdata  in  32  write data
- cfg_busy  out  1  transaction in flight; requests ignored
- cfg_ack  out  1  one-cycle completion pulse
- cfg_err  out  1  valid with cfg_ack; 1 = resp!=OKAY, illegal request, or timeout
- cfg_rdata  out  32  read data, valid with cfg_ack on reads, held until next read ack
- awvalid/awaddr[ADDR_WIDTH]/awready, wvalid/wdata[32]/wstrb[4]/wready, bvalid/bresp[2]/bready, arvalid/araddr[ADDR_WIDTH]/arready, rvalid/rdata[32]/rresp[2]/rready: standard AXI-Lite master directions

## Operation
- States: IDLE, WR (aw+w), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: cfg_wr alone -> capture addr/data, go WR; cfg_rd alone -> capture addr, go RD_ADDR; both together -> DONE with cfg_err=1, no bus traffic.
- Requests arriving outside IDLE are dropped silently; cfg_busy=1 in every state but IDLE.
- WR: awvalid and wvalid rise together; each drops independently after its own handshake; go WR_RESP once both done (same cycle allowed). wstrb fixed 4'hF. Master must not wait for awready before asserting wvalid, and must hold wvalid if the slave only asserts wready after address acceptance.
- WR_RESP: bready=1; on bvalid -> DONE, err = (bresp!=0).
- RD_ADDR: arvalid=1 until arready -> RD_DATA. RD_DATA: rready=1; on rvalid capture rdata, err=(rresp!=0) -> DONE.
- DONE: cfg_ack=1 for exactly one cycle -> IDLE.
- awaddr/araddr/wdata held stable while valid is high.

## Timing
- Reset values: all valids, bready, rready, cfg_ack, cfg_err, cfg_busy = 0; cfg_rdata = 0; addr/data outputs 0; state IDLE.
- All outputs registered. Request at cycle N -> awvalid/wvalid (or arvalid) high at N+1.
- Zero-wait slave: write ack at N+3 minimum when aw/w/b complete back-to-back; ack is the cycle after the final b/r handshake.
- Next request accepted in the cycle cfg_ack is high (state already IDLE on the following edge is not required; the ack cycle counts as DONE, busy=1).
- Reset mid-transaction: all channels drop immediately, no ack issued.

## Configuration
- AXIL_CFG_MASTER_TIMEOUT_EN defined: counter cleared on leaving IDLE, increments each non-IDLE cycle; at TIMEOUT_CYCLES-1 all valids/readies drop, go DONE with cfg_err=1, cfg_rdata=32'hDEAD_DEAD (deliberate recovery from a hung slave).
- Undefined: no counter; FSM waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Package axil_cfg_master_pkg: state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10), TIMEOUT_RDATA constant.
- Single flat module; no sub-module needed.

## Test plan
- cfg_wr addr 0x10, data 0xA5A5_5A5A, zero-wait slave -> aw/w at N+1, ack err=0 at N+3; readback of 0x10 -> cfg_rdata 0xA5A5_5A5A, err=0.
- Slave delays awready 3 cycles and wready until after aw -> wvalid held high throughout, single ack, err=0.
- cfg_wr and cfg_rd same cycle -> no valid ever asserted, ack with err=1 at N+1.
- Slave returns rresp=2'b10 on read -> ack with err=1, cfg_rdata = slave rdata.
- Second cfg_rd issued while busy -> ignored; exactly one ar handshake observed.
- Macro defined, TIMEOUT_CYCLES=16, slave never asserts bvalid -> ack err=1 at 16 cycles after leaving IDLE, bready drops; rst_n low mid-write -> all outputs 0 immediately.
